// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug-RAM controller shared by JTAG memory commands and an Avalon-MM slave.
// A pending JTAG access always wins arbitration over a new Avalon request.
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              mon_rd_valid,
  output logic              cmd_overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, J_RD, J_DONE, A_RD, A_DONE} state_t;

  state_t            state_reg, state_next;
  logic              slot_valid_reg;
  logic              slot_write_reg;
  logic [31:0]       slot_data_reg;
  logic [31:0]       mon_d_reg;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              mon_valid_reg;
  logic              overrun_reg;
  logic [31:0]       rdata_reg;
  logic              wait_reg;

  logic              ram_re;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  logic              addr_load;
  logic              cmd_load;
  logic              cmd_write;
  logic              slot_accept;
  logic              cmd_drop;
  logic              slot_clear;
  logic              mon_inc;
  logic              mon_capture;
  logic              rdata_capture;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // One narrow RAM per byte lane gives byte writes without read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (ram_we[gi]) begin
        lane_mem[ram_addr] <= ram_wdata[gi*8 +: 8];
      end
      if (ram_re) begin
        lane_q <= lane_mem[ram_addr];
      end
    end

    assign ram_q[gi*8 +: 8] = lane_q;
  end

  // Strobe decode; priority b > a > no_action if several are raised.
  always_comb begin
    addr_load = 1'b0;
    cmd_load  = 1'b0;
    cmd_write = 1'b0;
    if (take_action_ocimem_b) begin
      cmd_load  = 1'b1;
      cmd_write = 1'b1;
    end else if (take_action_ocimem_a) begin
      addr_load = 1'b1;
      cmd_load  = jdo[34];
    end else if (take_no_action_ocimem_a) begin
      cmd_load = 1'b1;
    end
  end

  // A dropped ocimem_a-with-read is discarded whole, address load included.
  assign slot_accept = cmd_load && !slot_valid_reg;
  assign cmd_drop    = cmd_load && slot_valid_reg;

  always_comb begin
    state_next    = state_reg;
    ram_re        = 1'b0;
    ram_we        = 4'b0000;
    ram_addr      = mon_a_reg;
    ram_wdata     = slot_data_reg;
    slot_clear    = 1'b0;
    mon_inc       = 1'b0;
    mon_capture   = 1'b0;
    rdata_capture = 1'b0;
    case (state_reg)
      IDLE: begin
        if (slot_valid_reg) begin
          if (slot_write_reg) begin
            ram_we     = 4'b1111;
            slot_clear = 1'b1;
            mon_inc    = 1'b1;
          end else begin
            ram_re     = 1'b1;
            state_next = J_RD;
          end
        end else if (avs_read) begin
          ram_re     = 1'b1;
          ram_addr   = avs_address;
          state_next = A_RD;
        end else if (avs_write) begin
          ram_addr   = avs_address;
          ram_wdata  = avs_writedata;
          ram_we     = avs_debugaccess ? avs_byteenable : 4'b0000;
          state_next = A_DONE;
        end
      end
      J_RD: begin
        mon_capture = 1'b1;
        mon_inc     = 1'b1;
        slot_clear  = 1'b1;
        state_next  = J_DONE;
      end
      J_DONE: state_next = IDLE;
      A_RD: begin
        rdata_capture = 1'b1;
        state_next    = A_DONE;
      end
      A_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      slot_valid_reg <= 1'b0;
      slot_write_reg <= 1'b0;
      slot_data_reg  <= 32'h0;
      mon_d_reg      <= 32'h0;
      mon_a_reg      <= '0;
      mon_valid_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      rdata_reg      <= 32'h0;
      wait_reg       <= 1'b1;
    end else begin
      state_reg     <= state_next;
      wait_reg      <= (state_next != A_DONE);
      mon_valid_reg <= mon_capture;
      if (mon_capture) begin
        mon_d_reg <= ram_q;
      end
      if (rdata_capture) begin
        rdata_reg <= ram_q;
      end
      // A fresh address load takes precedence over a concurrent auto-increment.
      if (addr_load && !cmd_drop) begin
        mon_a_reg <= jdo[26 +: ADDR_W];
      end else if (mon_inc) begin
        mon_a_reg <= mon_a_reg + ADDR_W'(1);
      end
      if (slot_accept) begin
        slot_valid_reg <= 1'b1;
        slot_write_reg <= cmd_write;
        slot_data_reg  <= jdo[34:3];
      end else if (slot_clear) begin
        slot_valid_reg <= 1'b0;
      end
      if (cmd_drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign avs_readdata    = rdata_reg;
  assign avs_waitrequest = wait_reg;
  assign MonDReg         = mon_d_reg;
  assign MonAReg         = mon_a_reg;
  assign mon_rd_valid    = mon_valid_reg;
  assign cmd_overrun     = overrun_reg;

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Bench for cpu_debug_ocimem_ctrl: directed scenarios plus random serialized
// JTAG/Avalon operations checked against a word-array memory model.
module tb_cpu_debug_ocimem_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_debugaccess;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic [ADDR_W-1:0] MonAReg;
  logic              mon_rd_valid;
  logic              cmd_overrun;

  cpu_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .mon_rd_valid            (mon_rd_valid),
    .cmd_overrun             (cmd_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: whole-word memory plus the JTAG address pointer.
  logic [31:0] model_mem [256];
  logic [7:0]  model_addr;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle right after a read strobe was sampled.
  task automatic jtag_read_finish(input string tag);
    logic [31:0] exp;
    exp = model_mem[model_addr];
    tick();
    check_eq({tag, "_early"}, 32'(mon_rd_valid), 32'd0);
    tick();
    check_eq({tag, "_valid"}, 32'(mon_rd_valid), 32'd1);
    check_eq({tag, "_data"}, MonDReg, exp);
    model_addr = model_addr + 8'd1;
    check_eq({tag, "_addr"}, 32'(MonAReg), 32'(model_addr));
    tick();
    check_eq({tag, "_pulse"}, 32'(mon_rd_valid), 32'd0);
    check_eq({tag, "_hold"}, MonDReg, exp);
    $display("jtag read  data=0x%08h next_addr=0x%02h", exp, model_addr);
  endtask

  task automatic jtag_addr(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[34] = rd;
    jdo[33:26] = a;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    model_addr = a;
    if (rd) begin
      jtag_read_finish("ja_rd");
    end else begin
      check_eq("ja_addr", 32'(MonAReg), 32'(a));
      check_eq("ja_novalid", 32'(mon_rd_valid), 32'd0);
      $display("jtag addr  addr=0x%02h", a);
    end
  endtask

  task automatic jtag_read();
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    jtag_read_finish("jn_rd");
  endtask

  task automatic jtag_write(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
    model_mem[model_addr] = data;
    $display("jtag write addr=0x%02h data=0x%08h", model_addr, data);
    model_addr = model_addr + 8'd1;
    check_eq("jw_addr", 32'(MonAReg), 32'(model_addr));
    check_eq("jw_novalid", 32'(mon_rd_valid), 32'd0);
  endtask

  task automatic avs_wr(input logic [7:0] a, input logic [31:0] data,
                        input logic [3:0] be, input logic dbg);
    avs_address = a;
    avs_writedata = data;
    avs_byteenable = be;
    avs_debugaccess = dbg;
    avs_write = 1'b1;
    check_eq("aw_wait_t0", 32'(avs_waitrequest), 32'd1);
    tick();
    check_eq("aw_wait_t1", 32'(avs_waitrequest), 32'd0);
    avs_write = 1'b0;
    if (dbg) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[a][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    tick();
    check_eq("aw_wait_after", 32'(avs_waitrequest), 32'd1);
    $display("avs write  addr=0x%02h data=0x%08h be=%b dbg=%0d", a, data, be, dbg);
  endtask

  task automatic avs_rd(input logic [7:0] a);
    avs_address = a;
    avs_read = 1'b1;
    tick();
    check_eq("ar_wait_t1", 32'(avs_waitrequest), 32'd1);
    tick();
    check_eq("ar_wait_t2", 32'(avs_waitrequest), 32'd0);
    check_eq("ar_data", avs_readdata, model_mem[a]);
    avs_read = 1'b0;
    tick();
    check_eq("ar_wait_after", 32'(avs_waitrequest), 32'd1);
    check_eq("ar_hold", avs_readdata, model_mem[a]);
    $display("avs read   addr=0x%02h data=0x%08h", a, avs_readdata);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    avs_debugaccess = 1'b0;
    model_addr = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_readdata", avs_readdata, 32'd0);
    check_eq("rst_wait", 32'(avs_waitrequest), 32'd1);
    check_eq("rst_mond", MonDReg, 32'd0);
    check_eq("rst_mona", 32'(MonAReg), 32'd0);
    check_eq("rst_valid", 32'(mon_rd_valid), 32'd0);
    check_eq("rst_overrun", 32'(cmd_overrun), 32'd0);

    // Fill the RAM so every later read has a known expectation.
    for (int i = 0; i < 256; i++) begin
      avs_address = i[7:0];
      avs_writedata = $urandom;
      avs_byteenable = 4'b1111;
      avs_debugaccess = 1'b1;
      avs_write = 1'b1;
      model_mem[i] = avs_writedata;
      tick();
      avs_write = 1'b0;
      tick();
    end

    // Address-only load, then three writes and read-back.
    jtag_addr(8'h10, 1'b0);
    jtag_write(32'hDEADBEEF);
    tick(); tick();
    jtag_write(32'h12345678);
    tick(); tick();
    jtag_write(32'hCAFEF00D);
    jtag_addr(8'h10, 1'b1);
    jtag_read();
    jtag_read();
    check_eq("seq_final_addr", 32'(MonAReg), 32'h13);

    // Address wrap on write.
    jtag_addr(8'hFF, 1'b0);
    jtag_write(32'hA5A5A5A5);
    check_eq("wrap_addr", 32'(MonAReg), 32'h00);
    jtag_addr(8'h00, 1'b1);
    jtag_addr(8'hFF, 1'b1);
    check_eq("wrap_data", MonDReg, 32'hA5A5A5A5);

    // Avalon byte-enabled and unprivileged writes.
    avs_wr(8'h20, 32'h0, 4'b1111, 1'b1);
    avs_wr(8'h20, 32'h11223344, 4'b0011, 1'b1);
    avs_wr(8'h20, 32'hFFFFFFFF, 4'b1111, 1'b0);
    avs_rd(8'h20);
    check_eq("be_word", avs_readdata, 32'h00003344);

    // Random serialized traffic.
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 4))
        0: jtag_addr(8'($urandom), 1'($urandom));
        1: jtag_write($urandom);
        2: jtag_read();
        3: avs_wr(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        default: avs_rd(8'($urandom));
      endcase
    end
    check_eq("no_overrun_yet", 32'(cmd_overrun), 32'd0);

    // Avalon read and JTAG read collide; a second strobe overruns.
    avs_address = 8'h20;
    avs_read = 1'b1;
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    check_eq("mix_wait_t1", 32'(avs_waitrequest), 32'd1);
    tick();
    take_no_action_ocimem_a = 1'b0;
    check_eq("mix_wait_t2", 32'(avs_waitrequest), 32'd0);
    check_eq("mix_avs_data", avs_readdata, model_mem[8'h20]);
    check_eq("mix_overrun", 32'(cmd_overrun), 32'd1);
    avs_read = 1'b0;
    tick();
    check_eq("mix_wait_t3", 32'(avs_waitrequest), 32'd1);
    check_eq("mix_valid_t3", 32'(mon_rd_valid), 32'd0);
    jtag_read_finish("mix_jrd");
    for (int k = 0; k < 4; k++) begin
      check_eq("mix_dropped", 32'(mon_rd_valid), 32'd0);
      check_eq("mix_addr_hold", 32'(MonAReg), 32'(model_addr));
      tick();
    end
    $display("mixed avs+jtag done, overrun=%0d", cmd_overrun);

    // Reset while a JTAG read is in J_RD.
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rmid_valid", 32'(mon_rd_valid), 32'd0);
    check_eq("rmid_mond", MonDReg, 32'd0);
    check_eq("rmid_mona", 32'(MonAReg), 32'd0);
    check_eq("rmid_wait", 32'(avs_waitrequest), 32'd1);
    check_eq("rmid_overrun", 32'(cmd_overrun), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rmid_quiet", 32'(mon_rd_valid), 32'd0);
      check_eq("rmid_wait_hi", 32'(avs_waitrequest), 32'd1);
    end
    $display("reset during J_RD done");
    model_addr = 8'd0;
    jtag_read();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ocimem_ctrl.md
Name: cpu_debug_ocimem_ctrl

Overview:
- System-clock consumer of the debug slave's `jdo` and `take_*_ocimem_*` strobes.
- Executes JTAG memory commands against a private debug RAM (reads, writes, address auto-increment) and returns read data on `MonDReg` for the next JTAG scan.
- Also exposes the same RAM to the CPU through an Avalon-MM slave with waitrequest, with fixed arbitration between the two sides.

Parameters:
- ADDR_W, 8, debug RAM word-address width; legal range 4..8; RAM depth is 2^ADDR_W × 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data word, stable when any strobe is high.
- take_action_ocimem_a  in  1  one-cycle strobe: address load, optional read.
- take_action_ocimem_b  in  1  one-cycle strobe: write `jdo[34:3]`.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address.
- avs_address  in  ADDR_W  Avalon word address.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_writedata  in  32  Avalon write data.
- avs_byteenable  in  4  Avalon byte enables.
- avs_debugaccess  in  1  write permission qualifier.
- avs_readdata  out  32  Avalon read data.
- avs_waitrequest  out  1  Avalon stall.
- MonDReg  out  32  last JTAG read data.
- MonAReg  out  ADDR_W  current JTAG word address.
- mon_rd_valid  out  1  one-cycle pulse when `MonDReg` is updated.
- cmd_overrun  out  1  sticky: a JTAG command was dropped.

Behaviour:
- Reset: all registered outputs go to 0 except `avs_waitrequest`, which goes to 1. The pending slot is cleared and the FSM returns to IDLE.
- RAM: synchronous, one-cycle read latency, byte-writable. It is inferred inside the block and has no reset, so its contents are preserved across reset.
- JTAG command decode. Strobes are mutually exclusive; if more than one is high, priority is b > a > no_action.
  - ocimem_a: `MonAReg <= jdo[26+ADDR_W-1:26]`. If `jdo[34]` = 1, also queue a read at the new address.
  - ocimem_b: queue a write of `jdo[34:3]`, all bytes, at `MonAReg`.
  - no_action_ocimem_a: queue a read at `MonAReg`.
- Pending slot: a 1-entry register for JTAG accesses.
  - A strobe that arrives while the slot is full is dropped and sets `cmd_overrun` (sticky until reset).
  - An address-only ocimem_a is never dropped.
- FSM states: IDLE, J_RD, J_DONE, A_RD, A_DONE.
- IDLE:
  - If the pending slot is full (the JTAG access has priority), take the JTAG access.
    - JTAG read: issue the RAM read, go to J_RD.
    - JTAG write: write the RAM this cycle, `MonAReg += 1`, clear the slot, stay in IDLE.
  - Otherwise, if `avs_read`: issue the RAM read at `avs_address`, go to A_RD.
  - Otherwise, if `avs_write`:
    - Write the RAM with `avs_byteenable` only if `avs_debugaccess` = 1; otherwise leave the RAM unchanged.
    - Go to A_DONE.
  - A strobe decoded in the same cycle is only placed in the slot. It executes no earlier than the next cycle.
- J_RD: `MonDReg <=` RAM output, `mon_rd_valid` = 1 next cycle, `MonAReg += 1`, clear the slot, go to J_DONE.
- J_DONE: return to IDLE.
- JTAG read latency: strobe at cycle t, `MonDReg` valid and pulse at t+3 when idle.
- A_RD: `avs_readdata <=` RAM output, go to A_DONE.
- A_DONE: `avs_waitrequest` = 0 for exactly this cycle, then return to IDLE.
- Avalon timing:
  - Read completes with waitrequest low at t+2.
  - Write completes with waitrequest low at t+1.
  - If the JTAG slot is busy, the Avalon latency extends by that JTAG access.
- `avs_waitrequest`: 0 only in A_DONE, 1 otherwise.
  - The Avalon master must hold its request until waitrequest is low.
  - A request deasserted early is treated as a master protocol error and need not be handled.
- Address wrap: `MonAReg` increments modulo 2^ADDR_W (all-ones → 0).
- Reset mid-operation: any in-flight access is abandoned.
  - A RAM write issued in the same cycle as reset may or may not land.
  - No `mon_rd_valid` or waitrequest-low is emitted after reset.
- `avs_readdata` and `MonDReg` hold their values between accesses.

Test Plan:
- Reset, then ocimem_a with `jdo[33:26]`=0x10, `jdo[34]`=0 → `MonAReg`=0x10, no `mon_rd_valid`, RAM untouched.
- Three ocimem_b strobes with data 0xDEADBEEF, 0x12345678, 0xCAFEF00D spaced 4 cycles apart, then ocimem_a with address 0x10 and `jdo[34]`=1, then no_action twice:
  - `MonDReg` = 0xDEADBEEF, then 0x12345678, then 0xCAFEF00D, each 3 cycles after its strobe.
  - `MonAReg` ends at 0x13.
- Set address 0xFF, write 0xA5A5A5A5, then read at 0x00 and 0xFF → the write lands at 0xFF; `MonAReg` wraps 0xFF→0x00 after the write.
- Avalon writes to 0x20:
  - debugaccess=1, byteenable=4'b0011, data 0x11223344 over 0 → word = 0x00003344, waitrequest low at t+1.
  - debugaccess=0 → word unchanged, waitrequest still low at t+1.
  - Avalon read of 0x20 → readdata = 0x00003344, waitrequest low at t+2.
- Avalon read and a no_action strobe in the same cycle, slot empty:
  - The Avalon read wins, completing at t+2.
  - The JTAG read follows, with `mon_rd_valid` at t+5.
  - A second strobe while the slot is full → `cmd_overrun`=1 and the command is dropped.
- Assert reset during J_RD → no `mon_rd_valid`, `MonDReg`=0, `MonAReg`=0, `avs_waitrequest`=1, `cmd_overrun`=0.
